mux_ctx_nto1: RTL and testbench
===============================

# mux_ctx_nto1

Parametrised, multi-context N-to-1 word multiplexer for the CGRA interconnect. It generalises the fixed 8-to-1 32-bit mux in three ways: input count and width are parameters; the select value lives in a serially loaded configuration chain rather than on a port; and several configuration contexts are cycled at run time. Each context can also choose between a combinational output and a registered output. It sits in processing-element and switchbox routing, on the same configuration chain as the other configurable cells.

## Interface
- `size`, default 32: data width in bits.
- `num_inputs`, default 8: number of data inputs, 2..64.
- `contexts`, default 2: number of configuration contexts, 1..16.
- Derived, not overridable:
  - `sel_width` = max(1, clog2(num_inputs)).
  - `cw` = `sel_width`+1, bits per context.
  - `chain_len` = `contexts`*`cw`.
  - `ctx_width` = max(1, clog2(contexts)).

Ports:
- `CGRA_Clock`, in, 1: the single clock.
- `CGRA_Reset`, in, 1: synchronous, active-high reset.
- `CGRA_Enable`, in, 1: run-mode advance enable.
- `Config_Enable`, in, 1: configuration shift enable.
- `ConfigIn`, in, 1: serial configuration input.
- `ConfigOut`, out, 1: serial configuration output, equal to chain bit 0.
- `in`, in, `num_inputs`*`size`: flattened data inputs; input i is `in[i*size +: size]`.
- `out`, out, `size`: selected data.
- `context_id`, out, `ctx_width`: current context index.

## Operation
- **Config chain**, `chain_len` bits.
  - When `Config_Enable`=1: chain <= {`ConfigIn`, chain[chain_len-1:1]}, a right shift.
  - After `chain_len` shifts, the first bit shifted in sits at bit 0.
  - Context k occupies chain[k*cw +: cw]: `sel` is the low `sel_width` bits and `reg_mode` is the MSB.
- **Context counter**.
  - Increments when `CGRA_Enable`=1 and `Config_Enable`=0.
  - Wraps from `contexts`-1 to 0.
  - With `contexts`=1 it stays at 0.
  - `context_id` = counter value.
- **Mux value** `mv` = input[`sel`] of the current context.
  - If `sel` >= `num_inputs`, `mv` = 0. The output is never X.
- **Output register** `oreg`: oreg <= `mv` on every cycle where `CGRA_Enable`=1 and `Config_Enable`=0; otherwise it holds.
- **Output select**: `out` = `reg_mode`(current context) ? `oreg` : `mv`.
- **Priority**: `CGRA_Reset` > `Config_Enable` > `CGRA_Enable`.
  - While configuring, the counter and `oreg` freeze.
  - `out` still follows the chain contents combinationally; downstream ignores it during configuration.

## Timing
- **Reset** (`CGRA_Reset`=1 at a rising edge):
  - chain = 0, counter = 0, `oreg` = 0.
  - Therefore `out` = input 0 (context 0 has `sel`=0, `reg_mode`=0).
  - `ConfigOut` = 0 and `context_id` = 0.
- **Reset mid-configuration or mid-run**: everything clears at that edge, and partially shifted configuration is lost.
- **Combinational mode** (`reg_mode`=0): 0-cycle latency from `in` to `out`.
- **Registered mode** (`reg_mode`=1): 1-cycle latency. `out` in cycle t+1 equals `mv` computed in cycle t, using cycle t's context `sel`.
  - With per-cycle context switching, the registered value is the previous context's selection. This is intentional: the previous context routes into a pipeline register.
- **`ConfigOut`**: updates 1 cycle after each shift, giving a chain delay of exactly `chain_len` cycles.
- **Context switch**: the counter changes on the edge where it is enabled; the new context's `sel` and `reg_mode` apply immediately after that edge.
- **`CGRA_Enable` and `Config_Enable` both high**: only the shift occurs.

## Test plan
1. **Reset value.** Defaults; assert reset for 2 cycles with `in` words = 0x11111111*(i+1).
   - Required: `out`=0x11111111, `context_id`=0, `ConfigOut`=0.
2. **Config load.** Defaults (`cw`=4, `chain_len`=8); shift bits for ctx0 {`reg_mode`=0, `sel`=5} and ctx1 {`reg_mode`=0, `sel`=2}, LSB first, ctx0 first; pulse `CGRA_Enable`.
   - Required: `out` alternates 0x66666666, 0x33333333.
   - Required: `context_id` alternates 0, 1.
3. **Registered mode.** ctx0 {`reg_mode`=1, `sel`=7} with `contexts`=1; change in7 from 0xA to 0xB at cycle t with enable high.
   - Required: `out`=0xB first at cycle t+1.
4. **Out-of-range select.** `num_inputs`=5, `sel`=6.
   - Required: `out`=0 with no X on any bit.
5. **Chain pass-through.** Shift a 16-bit pattern 0xA5C3 through a 2-context default chain.
   - Required: `ConfigOut` reproduces the first 8 input bits delayed by exactly 8 cycles.
6. **Freeze, then reset mid-configuration.**
   - Hold `Config_Enable`=1 and `CGRA_Enable`=1 for 3 cycles. Required: `context_id` and `oreg` are unchanged.
   - Then assert reset after 3 of 8 shifts. Required: chain reads all-zero and `out`=input 0.

Source files
------------

// File: rtl/mux_ctx_nto1.sv
// mux_ctx_nto1
// Multi-context N-to-1 word multiplexer for the CGRA interconnect.
// Each context holds a select value and a registered/combinational flag in a
// serially loaded configuration chain; contexts are cycled at run time.
//
// Ports:
//   CGRA_Clock    - single clock
//   CGRA_Reset    - synchronous active-high reset (clears chain, context, oreg)
//   CGRA_Enable   - run-mode advance: steps the context and loads oreg
//   Config_Enable - shifts the configuration chain (wins over CGRA_Enable)
//   ConfigIn      - serial configuration input (enters at the chain MSB)
//   ConfigOut     - serial configuration output (chain bit 0)
//   in            - flattened data inputs, input i at in[i*size +: size]
//   out           - selected word (combinational or registered per context)
//   context_id    - current context index
module mux_ctx_nto1 #(
  parameter int size       = 32,
  parameter int num_inputs = 8,
  parameter int contexts   = 2,
  localparam int sel_width = ($clog2(num_inputs) > 1) ? $clog2(num_inputs) : 1,
  localparam int cw        = sel_width + 1,
  localparam int chain_len = contexts * cw,
  localparam int ctx_width = ($clog2(contexts) > 1) ? $clog2(contexts) : 1
) (
  input  logic                         CGRA_Clock,
  input  logic                         CGRA_Reset,
  input  logic                         CGRA_Enable,
  input  logic                         Config_Enable,
  input  logic                         ConfigIn,
  output logic                         ConfigOut,
  input  logic [num_inputs*size-1:0]   in,
  output logic [size-1:0]              out,
  output logic [ctx_width-1:0]         context_id
);

  logic [chain_len-1:0] chain_q, chain_d;
  logic [ctx_width-1:0] ctx_q, ctx_d;
  logic [size-1:0]      oreg_q, oreg_d;

  logic [cw-1:0]        cur_cfg_s;
  logic [sel_width-1:0] sel_s;
  logic                 reg_mode_s;
  logic [size-1:0]      mv_s;

  // Pick the active context's configuration field out of the chain.
  // An OR of masked slices avoids a variable part-select on the chain.
  always_comb begin
    cur_cfg_s = '0;
    for (int k = 0; k < contexts; k++) begin
      cur_cfg_s = cur_cfg_s |
                  ((ctx_q == ctx_width'(k)) ? chain_q[k*cw +: cw] : {cw{1'b0}});
    end
    sel_s      = cur_cfg_s[sel_width-1:0];
    reg_mode_s = cur_cfg_s[cw-1];
  end

  // Data mux: a select with no matching input leaves the word at zero,
  // so out-of-range selects produce 0 rather than X.
  always_comb begin
    mv_s = '0;
    for (int i = 0; i < num_inputs; i++) begin
      mv_s = mv_s |
             ((sel_s == sel_width'(i)) ? in[i*size +: size] : {size{1'b0}});
    end
  end

  // Next-state: configuration shift has priority and freezes run-mode state.
  always_comb begin
    chain_d = chain_q;
    ctx_d   = ctx_q;
    oreg_d  = oreg_q;
    if (Config_Enable) begin
      chain_d = {ConfigIn, chain_q[chain_len-1:1]};
    end else if (CGRA_Enable) begin
      // oreg captures the current context's selection before the switch,
      // so in registered mode the previous context feeds the pipeline stage.
      oreg_d = mv_s;
      if (ctx_q == ctx_width'(contexts - 1)) begin
        ctx_d = '0;
      end else begin
        ctx_d = ctx_q + ctx_width'(1);
      end
    end else begin
      oreg_d = oreg_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      chain_q <= '0;
      ctx_q   <= '0;
      oreg_q  <= '0;
    end else begin
      chain_q <= chain_d;
      ctx_q   <= ctx_d;
      oreg_q  <= oreg_d;
    end
  end

  // Output select: combinational mux path or the pipeline register.
  always_comb begin
    if (reg_mode_s) begin
      out = oreg_q;
    end else begin
      out = mv_s;
    end
  end

  assign ConfigOut  = chain_q[0];
  assign context_id = ctx_q;

endmodule

// File: tb/tb_mux_ctx_nto1.sv
// Testbench for mux_ctx_nto1: three instances cover the default 8x32/2-context
// build, a single-context build in registered mode, and a 5-input build for
// out-of-range selects. Expected values are pushed to a scoreboard queue when
// stimulus is driven and popped when the output is sampled.
module tb_mux_ctx_nto1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (8 inputs, 2 contexts)
  logic         en_a = 1'b0, cfg_en_a = 1'b0, cfg_in_a = 1'b0, cfo_a;
  logic [255:0] in_a;
  logic [31:0]  out_a;
  logic [0:0]   ctx_a;

  // Instance R: 8 inputs, 1 context
  logic         en_r = 1'b0, cfg_en_r = 1'b0, cfg_in_r = 1'b0, cfo_r;
  logic [255:0] in_r;
  logic [31:0]  out_r;
  logic [0:0]   ctx_r;

  // Instance C: 5 inputs, 1 context
  logic         en_c = 1'b0, cfg_en_c = 1'b0, cfg_in_c = 1'b0, cfo_c;
  logic [159:0] in_c;
  logic [31:0]  out_c;
  logic [0:0]   ctx_c;

  mux_ctx_nto1 u_dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .CGRA_Enable(en_a),
    .Config_Enable(cfg_en_a), .ConfigIn(cfg_in_a), .ConfigOut(cfo_a),
    .in(in_a), .out(out_a), .context_id(ctx_a)
  );

  mux_ctx_nto1 #(.size(32), .num_inputs(8), .contexts(1)) u_dut_r (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .CGRA_Enable(en_r),
    .Config_Enable(cfg_en_r), .ConfigIn(cfg_in_r), .ConfigOut(cfo_r),
    .in(in_r), .out(out_r), .context_id(ctx_r)
  );

  mux_ctx_nto1 #(.size(32), .num_inputs(5), .contexts(1)) u_dut_c (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .CGRA_Enable(en_c),
    .Config_Enable(cfg_en_c), .ConfigIn(cfg_in_c), .ConfigOut(cfo_c),
    .in(in_c), .out(out_c), .context_id(ctx_c)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, obs, 64'hxxxx_xxxx_xxxx_xxxx);
    end else begin
      chk(tag, obs, sb_q.pop_front());
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_a(input int i);
    return 32'h11111111 * 32'(i + 1);
  endfunction

  int          sel_tab [2];
  int          m_ctx;
  logic [31:0] m_oreg;
  logic [15:0] pat;
  logic [7:0]  cfg8;
  logic [3:0]  nib;

  initial begin
    for (int i = 0; i < 8; i++) in_a[i*32 +: 32] = word_a(i);
    for (int i = 0; i < 8; i++) in_r[i*32 +: 32] = 32'h0;
    in_r[7*32 +: 32] = 32'hA;
    for (int i = 0; i < 5; i++) in_c[i*32 +: 32] = 32'hC0DE0000 + 32'(i);

    // 1. Reset value
    rst = 1'b1;
    tick(); tick();
    sb_push(64'h11111111); sb_push(64'h0); sb_push(64'h0);
    sb_check("rst_out", {32'h0, out_a});
    sb_check("rst_ctx", {63'h0, ctx_a});
    sb_check("rst_cfo", {63'h0, cfo_a});
    rst = 1'b0;

    // 2. Config load: ctx0 {0,sel=5}, ctx1 {0,sel=2}, LSB first, ctx0 first
    sel_tab[0] = 5; sel_tab[1] = 2;
    cfg8 = {4'h2, 4'h5};
    for (int i = 0; i < 8; i++) begin
      cfg_en_a = 1'b1; cfg_in_a = cfg8[i];
      tick();
    end
    cfg_en_a = 1'b0;
    m_ctx = 0; m_oreg = 32'h0;
    sb_push({32'h0, word_a(sel_tab[m_ctx])}); sb_push(64'(m_ctx));
    sb_check("load_out0", {32'h0, out_a});
    sb_check("load_ctx0", {63'h0, ctx_a});
    en_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      m_oreg = word_a(sel_tab[m_ctx]);
      m_ctx  = (m_ctx + 1) % 2;
      tick();
      sb_push({32'h0, word_a(sel_tab[m_ctx])}); sb_push(64'(m_ctx));
      sb_check("load_out", {32'h0, out_a});
      sb_check("load_ctx", {63'h0, ctx_a});
    end
    m_oreg = word_a(sel_tab[m_ctx]);
    m_ctx  = (m_ctx + 1) % 2;
    tick();
    en_a = 1'b0;

    // 6. Freeze while configuring, then reset after 3 of 8 shifts
    en_a = 1'b1; cfg_en_a = 1'b1; cfg_in_a = 1'b1;
    tick(); tick(); tick();
    en_a = 1'b0; cfg_en_a = 1'b0;
    sb_push(64'(m_ctx)); sb_push({32'h0, m_oreg});
    sb_check("frz_ctx", {63'h0, ctx_a});
    sb_check("frz_oreg", {32'h0, u_dut.oreg_q});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_push(64'h0); sb_push(64'h11111111); sb_push(64'h0); sb_push(64'h0);
    sb_check("mrst_chain", {56'h0, u_dut.chain_q});
    sb_check("mrst_out", {32'h0, out_a});
    sb_check("mrst_cfo", {63'h0, cfo_a});
    sb_check("mrst_ctx", {63'h0, ctx_a});

    // 5. Chain pass-through: ConfigOut lags ConfigIn by exactly 8 shifts
    pat = 16'hA5C3;
    for (int j = 0; j < 16; j++) begin
      cfg_en_a = 1'b1; cfg_in_a = pat[j];
      sb_push((j >= 7) ? 64'(pat[j-7]) : 64'h0);
      tick();
      sb_check($sformatf("pass_%0d", j), {63'h0, cfo_a});
    end
    cfg_en_a = 1'b0;

    // 3. Registered mode: ctx0 {reg_mode=1, sel=7}, contexts=1
    for (int i = 0; i < 4; i++) begin
      cfg_en_r = 1'b1; cfg_in_r = 1'b1;
      tick();
    end
    cfg_en_r = 1'b0;
    en_r = 1'b1;
    tick();
    sb_push(64'hA);
    sb_check("reg_first", {32'h0, out_r});
    in_r[7*32 +: 32] = 32'hB;
    sb_push(64'hA);
    #1 sb_check("reg_same_cycle", {32'h0, out_r});
    tick();
    sb_push(64'hB);
    sb_check("reg_next_cycle", {32'h0, out_r});
    en_r = 1'b0;
    in_r[7*32 +: 32] = 32'hC;
    tick();
    sb_push(64'hB);
    sb_check("reg_hold", {32'h0, out_r});
    en_r = 1'b1;
    tick();
    sb_push(64'hC);
    sb_check("reg_reload", {32'h0, out_r});
    en_r = 1'b0;

    // 4. Out-of-range select on a 5-input build (sel=4 in range, sel=6 out)
    nib = 4'h4;
    for (int i = 0; i < 4; i++) begin
      cfg_en_c = 1'b1; cfg_in_c = nib[i];
      tick();
    end
    sb_push(64'hC0DE0004);
    sb_check("sel4_out", {32'h0, out_c});
    nib = 4'h6;
    for (int i = 0; i < 4; i++) begin
      cfg_en_c = 1'b1; cfg_in_c = nib[i];
      tick();
    end
    cfg_en_c = 1'b0;
    sb_push(64'h0); sb_push(64'h0);
    sb_check("oor_out", {32'h0, out_c});
    sb_check("oor_nox", {63'h0, $isunknown(out_c)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
